// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : MIPS write-back stage. Holds the 32x32 register file and provides
//            two combinational read ports with same-cycle write-to-read bypass.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_07FC,
    parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] WB_inA,
    input  logic [31:0] WB_inB,
    input  logic [31:0] WB_PC,
    input  logic [1:0]  WB_MemtoReg,
    input  logic [1:0]  WB_RegDst,
    input  logic        WB_RegWr,
    input  logic [4:0]  WB_WrReg,
    input  logic [4:0]  WB_rd,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    output logic [31:0] ID_DataA,
    output logic [31:0] ID_DataB,
    output logic [4:0]  WB_WrAddr,
    output logic [31:0] WB_WrData,
    output logic        WB_WrEn
);

    localparam logic [4:0] c_REG_ZERO = 5'd0;
    localparam logic [4:0] c_REG_K0   = 5'd26;
    localparam logic [4:0] c_REG_GP   = 5'd28;
    localparam logic [4:0] c_REG_SP   = 5'd29;
    localparam logic [4:0] c_REG_RA   = 5'd31;

    logic [31:0] r_regs [32];
    logic [4:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic        w_wr_en;
    logic [30:0] w_pc_plus4_low;

    // The increment wraps inside the low 31 bits so the supervisor bit survives.
    assign w_pc_plus4_low = WB_PC[30:0] + 31'd4;

    always_comb begin
        w_wr_addr = WB_rd;
        case (WB_RegDst)
            2'd0: w_wr_addr = WB_rd;
            2'd1: w_wr_addr = WB_WrReg;
            2'd2: w_wr_addr = c_REG_RA;
            2'd3: w_wr_addr = c_REG_K0;
            default: w_wr_addr = WB_rd;
        endcase
    end

    always_comb begin
        w_wr_data = WB_inA;
        case (WB_MemtoReg)
            2'd0: w_wr_data = WB_inA;
            2'd1: w_wr_data = WB_inB;
            2'd2: w_wr_data = {WB_PC[31], w_pc_plus4_low};
            2'd3: w_wr_data = WB_PC;
            default: w_wr_data = WB_inA;
        endcase
    end

    assign w_wr_en   = WB_RegWr && (w_wr_addr != c_REG_ZERO);
    assign WB_WrAddr = w_wr_addr;
    assign WB_WrData = w_wr_data;
    assign WB_WrEn   = w_wr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                if (5'(i) == c_REG_SP)
                    r_regs[i] <= SP_INIT;
                else if (5'(i) == c_REG_GP)
                    r_regs[i] <= GP_INIT;
                else
                    r_regs[i] <= 32'd0;
            end
        end else if (w_wr_en) begin
            r_regs[w_wr_addr] <= w_wr_data;
        end
    end

    // r0 is hard-wired; the bypass lets ID consume a result written this cycle.
    always_comb begin
        if (ID_rs == c_REG_ZERO)
            ID_DataA = 32'd0;
        else if (w_wr_en && (ID_rs == w_wr_addr))
            ID_DataA = w_wr_data;
        else
            ID_DataA = r_regs[ID_rs];
    end

    always_comb begin
        if (ID_rt == c_REG_ZERO)
            ID_DataB = 32'd0;
        else if (w_wr_en && (ID_rt == w_wr_addr))
            ID_DataB = w_wr_data;
        else
            ID_DataB = r_regs[ID_rt];
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Directed self-checking bench for the write-back register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    localparam logic [31:0] c_SP_INIT = 32'h0000_07FC;
    localparam logic [31:0] c_GP_INIT = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] WB_inA;
    logic [31:0] WB_inB;
    logic [31:0] WB_PC;
    logic [1:0]  WB_MemtoReg;
    logic [1:0]  WB_RegDst;
    logic        WB_RegWr;
    logic [4:0]  WB_WrReg;
    logic [4:0]  WB_rd;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic [31:0] ID_DataA;
    logic [31:0] ID_DataB;
    logic [4:0]  WB_WrAddr;
    logic [31:0] WB_WrData;
    logic        WB_WrEn;

    int n_compared;
    int n_mismatched;

    wb_regfile #(
        .SP_INIT (c_SP_INIT),
        .GP_INIT (c_GP_INIT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .WB_inA      (WB_inA),
        .WB_inB      (WB_inB),
        .WB_PC       (WB_PC),
        .WB_MemtoReg (WB_MemtoReg),
        .WB_RegDst   (WB_RegDst),
        .WB_RegWr    (WB_RegWr),
        .WB_WrReg    (WB_WrReg),
        .WB_rd       (WB_rd),
        .ID_rs       (ID_rs),
        .ID_rt       (ID_rt),
        .ID_DataA    (ID_DataA),
        .ID_DataB    (ID_DataB),
        .WB_WrAddr   (WB_WrAddr),
        .WB_WrData   (WB_WrData),
        .WB_WrEn     (WB_WrEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        WB_inA       = '0;
        WB_inB       = '0;
        WB_PC        = '0;
        WB_MemtoReg  = 2'd0;
        WB_RegDst    = 2'd0;
        WB_RegWr     = 1'b0;
        WB_WrReg     = '0;
        WB_rd        = '0;
        ID_rs        = '0;
        ID_rt        = '0;
        tick();
        reset = 1'b0;

        // Reset values
        ID_rs = 5'd0;  ID_rt = 5'd5;  #1;
        check_eq("rst_r0", ID_DataA, 32'd0);
        check_eq("rst_r5", ID_DataB, 32'd0);
        ID_rs = 5'd28; ID_rt = 5'd29; #1;
        check_eq("rst_gp", ID_DataA, c_GP_INIT);
        check_eq("rst_sp", ID_DataB, c_SP_INIT);

        // ALU result to rd with same-cycle bypass
        WB_inA = 32'h1234_5678; WB_MemtoReg = 2'd0; WB_RegDst = 2'd0;
        WB_rd = 5'd8; WB_RegWr = 1'b1; ID_rs = 5'd8; ID_rt = 5'd8; #1;
        check_eq("alu_wren", {31'd0, WB_WrEn}, 32'd1);
        check_eq("alu_addr", {27'd0, WB_WrAddr}, 32'd8);
        check_eq("alu_bypA", ID_DataA, 32'h1234_5678);
        check_eq("alu_bypB", ID_DataB, 32'h1234_5678);
        tick();
        WB_RegWr = 1'b0; #1;
        check_eq("alu_r8", ID_DataA, 32'h1234_5678);

        // Without RegWr no bypass: old value of r8 stays visible
        WB_inA = 32'hAAAA_0000; #1;
        check_eq("nowr_wren", {31'd0, WB_WrEn}, 32'd0);
        check_eq("nowr_data", WB_WrData, 32'hAAAA_0000);
        check_eq("nowr_r8", ID_DataA, 32'h1234_5678);
        tick();
        check_eq("nowr_r8_hold", ID_DataA, 32'h1234_5678);

        // Write to r0 is dropped
        WB_rd = 5'd0; WB_inA = 32'hFFFF_FFFF; WB_RegWr = 1'b1; ID_rs = 5'd0; #1;
        check_eq("r0_wren", {31'd0, WB_WrEn}, 32'd0);
        check_eq("r0_data", WB_WrData, 32'hFFFF_FFFF);
        check_eq("r0_pre", ID_DataA, 32'd0);
        tick();
        check_eq("r0_post", ID_DataA, 32'd0);

        // jal: PC+4 to r31, supervisor bit kept
        WB_PC = 32'h8000_0010; WB_MemtoReg = 2'd2; WB_RegDst = 2'd2; WB_RegWr = 1'b1; #1;
        check_eq("jal_addr", {27'd0, WB_WrAddr}, 32'd31);
        check_eq("jal_data", WB_WrData, 32'h8000_0014);
        tick();
        WB_RegWr = 1'b0; ID_rs = 5'd31; #1;
        check_eq("jal_r31", ID_DataA, 32'h8000_0014);
        WB_PC = 32'hFFFF_FFFC; WB_RegDst = 2'd0; WB_rd = 5'd10; WB_RegWr = 1'b1; #1;
        check_eq("wrap_data", WB_WrData, 32'h8000_0000);
        tick();
        WB_RegWr = 1'b0; ID_rs = 5'd10; #1;
        check_eq("wrap_r10", ID_DataA, 32'h8000_0000);
        WB_PC = 32'h7FFF_FFFC; #1;
        check_eq("wrap_nosup", WB_WrData, 32'h0000_0000);

        // Interrupt return address to k0, then memory data to rt
        WB_PC = 32'h0000_0040; WB_MemtoReg = 2'd3; WB_RegDst = 2'd3; WB_RegWr = 1'b1; #1;
        check_eq("int_addr", {27'd0, WB_WrAddr}, 32'd26);
        tick();
        WB_MemtoReg = 2'd1; WB_RegDst = 2'd1; WB_WrReg = 5'd9; WB_inB = 32'hDEAD_BEEF;
        ID_rs = 5'd26; ID_rt = 5'd9; #1;
        check_eq("int_r26", ID_DataA, 32'h0000_0040);
        check_eq("mem_bypB", ID_DataB, 32'hDEAD_BEEF);
        tick();
        WB_RegWr = 1'b0; #1;
        check_eq("mem_r9", ID_DataB, 32'hDEAD_BEEF);

        // Reset beats a simultaneous write; both ports bypass during the write
        WB_MemtoReg = 2'd0; WB_RegDst = 2'd1; WB_WrReg = 5'd29; WB_inA = 32'h0000_0055;
        WB_RegWr = 1'b1; reset = 1'b1; ID_rs = 5'd29; ID_rt = 5'd29; #1;
        check_eq("rstwr_bypA", ID_DataA, 32'h0000_0055);
        check_eq("rstwr_bypB", ID_DataB, 32'h0000_0055);
        tick();
        reset = 1'b0; WB_RegWr = 1'b0; #1;
        check_eq("rstwr_sp", ID_DataA, c_SP_INIT);
        ID_rt = 5'd8; #1;
        check_eq("rstwr_r8clr", ID_DataB, 32'd0);
        ID_rt = 5'd29; WB_RegWr = 1'b1; #1;
        check_eq("sp_bypA", ID_DataA, 32'h0000_0055);
        check_eq("sp_bypB", ID_DataB, 32'h0000_0055);
        tick();
        WB_RegWr = 1'b0; #1;
        check_eq("sp_r29", ID_DataA, 32'h0000_0055);
        check_eq("sp_r29B", ID_DataB, 32'h0000_0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
